// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if: request/response bundle between the register-read stage
// and the handshaked ALU execute stage.
`default_nettype none

interface alu_exec_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      operation;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, operation, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, operation, illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq : handshaked ALU decode + execute stage, iterative shift-add MUL
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_exec_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_BPC  = 1,
  parameter int ENABLE_M = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_seq_if.slave bus
);

  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] a_q, b_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q, out_valid_q, zero_q, illegal_q;
  logic [XLEN-1:0] result_q;
  logic [3:0]      operation_q;

  logic [3:0]      dec_op;
  logic [3:0]      base_op;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] partial;
  logic [XLEN-1:0] acc_nxt;
  logic [SHW-1:0]  shamt;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.operation = operation_q;
  assign bus.illegal   = illegal_q;

  // funct3 mapping shared by R-type (funct7=0) and I-type
  always_comb begin
    base_op = OP_ADD;
    case (bus.funct3)
      3'b000: base_op = OP_ADD;
      3'b001: base_op = OP_SLL;
      3'b010: base_op = OP_SLT;
      3'b011: base_op = OP_SLTU;
      3'b100: base_op = OP_XOR;
      3'b101: base_op = OP_SRL;
      3'b110: base_op = OP_OR;
      3'b111: base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  end

  always_comb begin
    dec_op = OP_ILL;
    case (bus.alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (bus.funct7 == 7'b0000000)
          dec_op = base_op;
        else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b000)
          dec_op = OP_SUB;
        else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b101)
          dec_op = OP_SRA;
        else if (bus.funct7 == 7'b0000001 && bus.funct3 == 3'b000 && ENABLE_M != 0)
          dec_op = OP_MUL;
        else
          dec_op = OP_ILL;
      end
      2'b11: begin
        // immediate forms: funct7 is immediate bits except for the shifts
        if (bus.funct3 == 3'b001)
          dec_op = (bus.funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
        else if (bus.funct3 == 3'b101) begin
          if (bus.funct7 == 7'b0000000)      dec_op = OP_SRL;
          else if (bus.funct7 == 7'b0100000) dec_op = OP_SRA;
          else                               dec_op = OP_ILL;
        end else
          dec_op = base_op;
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign shamt = b_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      default: alu_res = '0;
    endcase
  end

  // one shift-add step: MUL_BPC multiplier bits per cycle
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mplier_q[j])
        partial = partial + (mcand_q << j);
    end
    acc_nxt = acc_q + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      operation_q <= OP_AND;
      illegal_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.op_a;
            b_q        <= bus.op_b;
            op_q       <= dec_op;
            in_ready_q <= 1'b0;
            if (dec_op == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= bus.op_a;
              mplier_q <= bus.op_b;
              cnt_q    <= CW'(STEPS);
              state    <= S_MUL;
            end else begin
              state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result_q    <= alu_res;
          zero_q      <= (alu_res == '0);
          operation_q <= op_q;
          illegal_q   <= (op_q == OP_ILL);
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        S_MUL: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << MUL_BPC;
          mplier_q <= mplier_q >> MUL_BPC;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_q    <= acc_nxt;
            zero_q      <= (acc_nxt == '0);
            operation_q <= op_q;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed vectors against three configurations of alu_exec_seq
// (defaults, MUL_BPC=4, ENABLE_M=0) sharing one request bus selected by sel.
`default_nettype none

module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  sel;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [2:0]  req_f3;
  logic [6:0]  req_f7;
  logic [31:0] req_a, req_b;
  logic        rsp_ready;

  logic        cur_in_ready, cur_out_valid, cur_zero, cur_illegal;
  logic [31:0] cur_result;
  logic [3:0]  cur_operation;

  always #5 clk = ~clk;

  alu_exec_seq_if #(.XLEN(32)) bus0 ();
  alu_exec_seq_if #(.XLEN(32)) bus4 ();
  alu_exec_seq_if #(.XLEN(32)) busn ();

  alu_exec_seq #(.XLEN(32), .MUL_BPC(1), .ENABLE_M(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  alu_exec_seq #(.XLEN(32), .MUL_BPC(4), .ENABLE_M(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  alu_exec_seq #(.XLEN(32), .MUL_BPC(1), .ENABLE_M(0)) dutn (.clk(clk), .rst_n(rst_n), .bus(busn.slave));

  assign bus0.in_valid  = req_valid && (sel == 2'd0);
  assign bus4.in_valid  = req_valid && (sel == 2'd1);
  assign busn.in_valid  = req_valid && (sel == 2'd2);
  assign bus0.out_ready = rsp_ready && (sel == 2'd0);
  assign bus4.out_ready = rsp_ready && (sel == 2'd1);
  assign busn.out_ready = rsp_ready && (sel == 2'd2);
  assign bus0.alu_op = req_op;  assign bus4.alu_op = req_op;  assign busn.alu_op = req_op;
  assign bus0.funct3 = req_f3;  assign bus4.funct3 = req_f3;  assign busn.funct3 = req_f3;
  assign bus0.funct7 = req_f7;  assign bus4.funct7 = req_f7;  assign busn.funct7 = req_f7;
  assign bus0.op_a   = req_a;   assign bus4.op_a   = req_a;   assign busn.op_a   = req_a;
  assign bus0.op_b   = req_b;   assign bus4.op_b   = req_b;   assign busn.op_b   = req_b;

  always_comb begin
    cur_in_ready  = bus0.in_ready;
    cur_out_valid = bus0.out_valid;
    cur_result    = bus0.result;
    cur_zero      = bus0.zero;
    cur_operation = bus0.operation;
    cur_illegal   = bus0.illegal;
    case (sel)
      2'd1: begin
        cur_in_ready = bus4.in_ready;  cur_out_valid = bus4.out_valid; cur_result  = bus4.result;
        cur_zero     = bus4.zero;      cur_operation = bus4.operation; cur_illegal = bus4.illegal;
      end
      2'd2: begin
        cur_in_ready = busn.in_ready;  cur_out_valid = busn.out_valid; cur_result  = busn.result;
        cur_zero     = busn.zero;      cur_operation = busn.operation; cur_illegal = busn.illegal;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; return cycles from accept until out_valid and
  // how many of those cycles in_ready was low.
  task automatic run_op(input logic [1:0] s, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy);
    int guard;
    guard = 0;
    sel = s; req_op = op; req_f3 = f3; req_f7 = f7; req_a = a; req_b = b;
    req_valid = 1'b1;
    while (!cur_in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; busy = 0;
    while (!cur_out_valid && lat < 200) begin
      if (!cur_in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] s, input logic [1:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic [3:0] exp_op, input int exp_lat);
    int lat, busy;
    run_op(s, op, f3, f7, a, b, lat, busy);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, cur_result, exp_res);
    chk({tag, "_zero"}, {31'd0, cur_zero}, {31'd0, exp_res == 32'd0});
    chk({tag, "_op"}, {28'd0, cur_operation}, {28'd0, exp_op});
    chk({tag, "_ill"}, {31'd0, cur_illegal}, {31'd0, exp_op == 4'b1111});
    take();
    chk({tag, "_vdrop"}, {31'd0, cur_out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, busy, bad;
    sel = 2'd0; req_valid = 1'b0; req_op = 2'b00; req_f3 = 3'b000; req_f7 = 7'b0;
    req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, cur_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, cur_out_valid}, 32'd0);
    chk("rst_result", cur_result, 32'd0);
    chk("rst_zero", {31'd0, cur_zero}, 32'd0);
    chk("rst_illegal", {31'd0, cur_illegal}, 32'd0);
    chk("rst_operation", {28'd0, cur_operation}, 32'd0);

    do_op("sub_r",    2'd0, 2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1);
    do_op("sub_br",   2'd0, 2'b01, 3'b111, 7'b1111111, 32'h1234, 32'h1234, 32'd0, 4'b0110, 1);
    do_op("srai",     2'd0, 2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0101, 1);
    do_op("add_ls",   2'd0, 2'b00, 3'b101, 7'b0100000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0010, 1);
    do_op("slt",      2'd0, 2'b10, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1);
    do_op("sltu",     2'd0, 2'b10, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 1);
    do_op("sll_wrap", 2'd0, 2'b10, 3'b001, 7'b0000000, 32'd1, 32'h25, 32'h20, 4'b0011, 1);
    do_op("srli",     2'd0, 2'b11, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'd1, 4'b0100, 1);
    do_op("xori",     2'd0, 2'b11, 3'b100, 7'b1010101, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b1100, 1);
    do_op("addi_f7",  2'd0, 2'b11, 3'b000, 7'b0100000, 32'd9, 32'd6, 32'd15, 4'b0010, 1);
    do_op("or",       2'd0, 2'b10, 3'b110, 7'b0000000, 32'hF0, 32'h0F, 32'hFF, 4'b0001, 1);
    do_op("and",      2'd0, 2'b10, 3'b111, 7'b0000000, 32'hF0, 32'h0F, 32'd0, 4'b0000, 1);
    do_op("ill_f7",   2'd0, 2'b10, 3'b000, 7'b0000011, 32'd5, 32'd7, 32'd0, 4'b1111, 1);
    do_op("ill_slli", 2'd0, 2'b11, 3'b001, 7'b0100000, 32'd5, 32'd1, 32'd0, 4'b1111, 1);
    do_op("ill_mulr", 2'd0, 2'b10, 3'b001, 7'b0000001, 32'd5, 32'd1, 32'd0, 4'b1111, 1);

    // MUL, then hold out_ready low with a new request pending
    run_op(2'd0, 2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd3, lat, busy);
    chk("mul1_lat", lat, 32);
    chk("mul1_busy", busy, 32);
    chk("mul1_res", cur_result, 32'hFFFF_FFFD);
    chk("mul1_op", {28'd0, cur_operation}, 32'h9);
    req_op = 2'b00; req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cur_out_valid !== 1'b1 || cur_result !== 32'hFFFF_FFFD || cur_in_ready !== 1'b0) bad++;
    end
    chk("hold_stable", bad, 0);
    take();
    chk("hold_vdrop", {31'd0, cur_out_valid}, 32'd0);
    chk("hold_ready", {31'd0, cur_in_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold_res_keep", cur_result, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    chk("resume_valid", {31'd0, cur_out_valid}, 32'd1);
    chk("resume_res", cur_result, 32'd30);
    take();

    do_op("mul4_a", 2'd1, 2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'b1001, 8);
    do_op("mul4_b", 2'd1, 2'b10, 3'b000, 7'b0000001, 32'h1234_5678, 32'h10, 32'h2345_6780, 4'b1001, 8);
    do_op("mul4_z", 2'd1, 2'b10, 3'b000, 7'b0000001, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b1001, 8);
    do_op("nom_mul", 2'd2, 2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd3, 32'd0, 4'b1111, 1);
    do_op("nom_add", 2'd2, 2'b10, 3'b000, 7'b0000000, 32'd4, 32'd3, 32'd7, 4'b0010, 1);

    // asynchronous reset in the tenth MUL cycle
    sel = 2'd0; req_op = 2'b10; req_f3 = 3'b000; req_f7 = 7'b0000001;
    req_a = 32'd7; req_b = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_busy", {31'd0, cur_in_ready}, 32'd0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, cur_out_valid}, 32'd0);
    chk("abort_res", cur_result, 32'd0);
    chk("abort_op", {28'd0, cur_operation}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, cur_in_ready}, 32'd1);
    do_op("post_rst_add", 2'd0, 2'b00, 3'b000, 7'b0000000, 32'd2, 32'd3, 32'd5, 4'b0010, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
